read_returner: RTL and testbench
================================

# read_returner

Reorder buffer between the back end's burst handler and the front end. The front end takes a read tag from this block before issuing each read toward the schedulers. Read data comes back from the burst handler's returner port, in any order, tagged with that index. This block stores the data per tag and releases it to the front end strictly in allocation order over a valid/ready handshake. Write completions from the same port are turned into an acknowledgement pulse.

## Interface
Parameters:
- DATA_W, 16, width of one returned data word (matches data_width)
- IDX_W, 6, tag width (matches read_entries_log); ENTRIES = 2**IDX_W slots

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  1  front end requests a read tag
- alloc_gnt  out  1  tag granted this cycle; equals alloc_req && !full
- alloc_index  out  IDX_W  tag being granted (tail pointer)
- in_valid  in  1  burst handler returner_valid
- in_type  in  1  returner_type: 0 = read, 1 = write
- in_data  in  DATA_W  returner_data
- in_index  in  IDX_W  returner_index
- out_valid  out  1  head slot holds data
- out_ready  in  1  front end accepts head
- out_data  out  DATA_W  data of head slot
- out_index  out  IDX_W  tag of head slot
- wr_ack  out  1  one-cycle pulse per write completion
- count  out  IDX_W+1  allocated, not yet popped slots
- err  out  1  sticky protocol error (see Configuration)

## Operation
- State: head and tail pointers (IDX_W bits, wrap modulo ENTRIES), count (IDX_W+1 bits), per-slot filled bit, per-slot data RAM, wr_ack register.
- full = (count == ENTRIES). empty = (count == 0).
- Allocation:
  - alloc_gnt = alloc_req && !full, combinational from registered count.
  - On grant, tail increments at the next edge and filled[tail] is cleared.
- Read return (in_valid && in_type == 0):
  - data[in_index] <= in_data.
  - filled[in_index] <= 1.
  - This block never backpressures the port; in_valid is accepted every cycle.
- Write return (in_valid && in_type == 1): wr_ack <= 1 for one cycle. Nothing is stored.
- Output:
  - out_valid = !empty && filled[head].
  - out_data = data[head]; out_index = head. Both combinational from registers.
  - Pop = out_valid && out_ready: filled[head] <= 0, head increments.
- count update: count <= count + grant − pop. Simultaneous grant and pop leaves count unchanged.
- Full case: a pop in the same cycle does not permit a grant. The freed slot is grantable one cycle later.
- Same-cycle return to the head slot does not raise out_valid until the next cycle.
- Reset mid-operation drops all stored data and outstanding tags. Returns arriving after reset for pre-reset tags are ignored when Configuration checking is on, and written blindly when it is off.

## Timing
- Reset values:
  - alloc_gnt follows alloc_req (count = 0), alloc_index = 0
  - out_valid = 0, out_data = 0, out_index = 0
  - wr_ack = 0, count = 0, err = 0
  - head = tail = 0, all filled = 0, data RAM cleared to 0
- Read return to visible out_valid: 1 cycle, when the returned tag is at head.
- Write return to wr_ack: 1 cycle.
- Pop to next head visible: 1 cycle. Back-to-back pops are sustained at 1 per cycle when slots are filled.
- out_data and out_index are held stable while out_valid && !out_ready.

## Configuration
- READ_RETURNER_CHECK_EN defined:
  - A read return to a slot that is not allocated (outside the head..tail window, or any slot when empty) is dropped and sets err.
  - A read return to a slot that is already filled is dropped and sets err.
  - In both cases data and filled are unchanged.
  - err clears only on rst.
- READ_RETURNER_CHECK_EN undefined:
  - Every read return writes the slot and sets filled unconditionally.
  - err is tied to 0.
  - No window-compare logic is built.

## Test plan
- Reset then alloc ×3 → alloc_index 0, 1, 2 with alloc_gnt high each cycle; count = 3.
- Out-of-order returns: with tags 0..2 allocated, return tag 2 (0xC), then tag 0 (0xA), then tag 1 (0xB); out_ready = 1 → pops 0xA/0, 0xB/1, 0xC/2 in that order, with no out_valid before tag 0 is returned.
- Full boundary: allocate 64 (IDX_W = 6) → count = 64, alloc_gnt low on next request. Pop one and request in the same cycle → no grant that cycle; grant with alloc_index = 0 the next cycle (wrap).
- Backpressure: head filled with 0x1234 and out_ready = 0 for 5 cycles → out_valid = 1 and out_data = 0x1234 stable; count unchanged; pop on the cycle out_ready rises.
- Write return: in_valid = 1, in_type = 1 → wr_ack = 1 for exactly one cycle; count and out_valid unchanged.
- With READ_RETURNER_CHECK_EN: return to tag 5 while only 0..2 are allocated → err = 1 and slot 5 is not filled. Return tag 1 twice → second return dropped, err stays 1, first data is popped.

Source files
------------

// File: rtl/read_returner.sv
// read_returner
//   Reorder buffer for read data coming back from the burst handler.
//   The front end takes a tag (alloc_*) before issuing each read. Data
//   returns in any order tagged with that index, is parked per slot, and is
//   released strictly in allocation order over out_valid/out_ready.
//   Write completions on the same port become a one-cycle wr_ack pulse.
//
// Optional feature macro: READ_RETURNER_CHECK_EN
//   defined   : read returns to unallocated or already-filled slots are
//               dropped and set the sticky err flag.
//   undefined : every read return writes its slot; err is tied to 0.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   alloc_req/gnt/index      tag allocation (gnt = req && !full, index = tail)
//   in_valid/type/data/index returner port (type 0 = read, 1 = write)
//   out_valid/ready/data/index  in-order release of the head slot
//   wr_ack                   one-cycle pulse per write completion
//   count                    allocated, not yet popped slots
//   err                      sticky protocol error
module read_returner #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              in_valid,
  input  logic              in_type,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              wr_ack,
  output logic [IDX_W:0]    count,
  output logic              err
);

  localparam int              ENTRIES  = 1 << IDX_W;
  localparam logic [IDX_W:0]  FULL_CNT = (IDX_W+1)'(ENTRIES);

  logic [IDX_W-1:0]               head, tail;
  logic [IDX_W:0]                 cnt;
  logic [ENTRIES-1:0]             filled;
  logic [ENTRIES-1:0][DATA_W-1:0] data_ram;
  logic                           wr_ack_q;

  logic full, empty, pop, rd_ret, rd_ok;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // Grant looks only at registered count: a pop while full frees the slot
  // for the following cycle, not this one.
  assign alloc_gnt   = alloc_req && !full;
  assign alloc_index = tail;

  assign out_valid = !empty && filled[head];
  assign out_data  = data_ram[head];
  assign out_index = head;
  assign pop       = out_valid && out_ready;

  assign rd_ret = in_valid && !in_type;

`ifdef READ_RETURNER_CHECK_EN
  logic [IDX_W-1:0] rel;
  logic             in_window;
  logic             err_q;

  // Distance from head modulo ENTRIES; the slot is live iff that distance
  // is below the occupancy. Covers wrap and the full (count == ENTRIES) case.
  assign rel       = in_index - head;
  assign in_window = ({1'b0, rel} < cnt);
  assign rd_ok     = rd_ret && in_window && !filled[in_index];

  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (rd_ret && !rd_ok) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign rd_ok = rd_ret;
  assign err   = 1'b0;
`endif

  // Pointers, occupancy and write acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      if (alloc_gnt) tail <= tail + 1'b1;
      if (pop)       head <= head + 1'b1;
      cnt      <= cnt + (IDX_W+1)'(alloc_gnt) - (IDX_W+1)'(pop);
      wr_ack_q <= in_valid && in_type;
    end
  end

  // Slot storage. Clears are listed before the return write so a return
  // wins on a slot collision; with legal traffic the three never overlap
  // (a returned slot is live and unfilled, so it is neither the popping
  // head nor the freshly granted tail).
  always_ff @(posedge clk) begin
    if (rst) begin
      filled   <= '0;
      data_ram <= '0;
    end else begin
      if (pop)       filled[head] <= 1'b0;
      if (alloc_gnt) filled[tail] <= 1'b0;
      if (rd_ok) begin
        filled[in_index]   <= 1'b1;
        data_ram[in_index] <= in_data;
      end
    end
  end

  assign wr_ack = wr_ack_q;
  assign count  = cnt;

endmodule

// File: tb/tb_read_returner.sv
module tb_read_returner;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 6;
  localparam int ENTRIES = 64;

  typedef logic [IDX_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] dat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_req;
  logic              alloc_gnt;
  tag_t              alloc_index;
  logic              in_valid;
  logic              in_type;
  dat_t              in_data;
  tag_t              in_index;
  logic              out_valid;
  logic              out_ready;
  dat_t              out_data;
  tag_t              out_index;
  logic              wr_ack;
  logic [IDX_W:0]    count;
  logic              err;

  read_returner #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_index(alloc_index),
    .in_valid(in_valid), .in_type(in_type), .in_data(in_data), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .wr_ack(wr_ack), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // exp_q holds outstanding tags in allocation order: it is the scoreboard
  // of responses the DUT owes, popped by the monitor when a pop is seen.
  tag_t  exp_q[$];
  dat_t  mdata   [ENTRIES];
  bit    mfilled [ENTRIES];
  tag_t  mhead, mtail;
  bit    mwrack, merr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare at negedge, then advance the model by what the coming
  // edge does with the inputs currently applied.
  always @(negedge clk) begin
    bit   exp_valid, gnt, pop, live, store;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < ENTRIES; i++) begin mdata[i] = '0; mfilled[i] = 1'b0; end
      mhead = '0; mtail = '0; mwrack = 1'b0; merr = 1'b0;
    end else begin
      gnt       = alloc_req && (exp_q.size() < ENTRIES);
      exp_valid = (exp_q.size() > 0) && mfilled[exp_q[0]];
      chk("alloc_gnt",   32'(alloc_gnt),   32'(gnt));
      chk("alloc_index", 32'(alloc_index), 32'(mtail));
      chk("out_valid",   32'(out_valid),   32'(exp_valid));
      chk("out_index",   32'(out_index),   32'(mhead));
      chk("out_data",    32'(out_data),    32'(mdata[mhead]));
      chk("count",       32'(count),       32'(exp_q.size()));
      chk("wr_ack",      32'(wr_ack),      32'(mwrack));
      chk("err",         32'(err),         32'(merr));
      pop = exp_valid && out_ready;

      // Decide the return on pre-edge state.
      store = 1'b0;
      if (in_valid && !in_type) begin
        live = 1'b0;
        foreach (exp_q[k]) if (exp_q[k] == in_index) live = 1'b1;
`ifdef READ_RETURNER_CHECK_EN
        if (live && !mfilled[in_index]) store = 1'b1;
        else merr = 1'b1;
`else
        store = 1'b1;
`endif
      end

      if (pop) begin
        void'(exp_q.pop_front());
        mfilled[mhead] = 1'b0;
        mhead++;
      end
      if (gnt) begin
        exp_q.push_back(mtail);
        mfilled[mtail] = 1'b0;
        mtail++;
      end
      if (store) begin
        mdata[in_index]   = in_data;
        mfilled[in_index] = 1'b1;
      end
      mwrack = in_valid && in_type;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit req, input bit iv, input bit ity,
                      input dat_t id, input tag_t ix, input bit rdy);
    alloc_req = req; in_valid = iv; in_type = ity;
    in_data = id; in_index = ix; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 0);
    rst = 1'b0;
  endtask

  // Randomized cycle: read returns only to live, not-yet-returned tags.
  task automatic rand_cycle(input bit allow_alloc, input bit force_rdy);
    tag_t pend[$];
    bit   req, iv, ity, rdy;
    tag_t ix;
    foreach (exp_q[k]) if (!mfilled[exp_q[k]]) pend.push_back(exp_q[k]);
    req = allow_alloc && ($urandom_range(0, 2) != 0);
    rdy = force_rdy || ($urandom_range(0, 3) != 0);
    iv  = ($urandom_range(0, 3) != 0);
    ity = (pend.size() == 0) || ($urandom_range(0, 5) == 0);
    ix  = (pend.size() == 0) ? tag_t'($urandom) : pend[$urandom_range(0, pend.size() - 1)];
    step(req, iv, ity, dat_t'($urandom), ix, rdy);
  endtask

  initial begin
    rst = 1'b1; alloc_req = 0; in_valid = 0; in_type = 0;
    in_data = '0; in_index = '0; out_ready = 0;
    do_reset();
    idle(1, 0);

    // Three allocations, out-of-order returns, in-order release.
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 0);
    step(0, 1, 0, 16'h000C, 6'd2, 1);
    idle(2, 1);
    step(0, 1, 0, 16'h000A, 6'd0, 1);
    step(0, 1, 0, 16'h000B, 6'd1, 1);
    idle(4, 1);

    // Write completion.
    step(0, 1, 1, 16'hBEEF, 6'd7, 0);
    idle(3, 0);

    // Backpressure on a filled head.
    step(1, 0, 0, '0, '0, 0);
    step(0, 1, 0, 16'h1234, 6'd3, 0);
    idle(5, 0);
    idle(2, 1);

    // Full boundary and wrap.
    do_reset();
    for (int i = 0; i < ENTRIES; i++) step(1, 0, 0, '0, '0, 0);
    step(1, 0, 0, '0, '0, 0);
    step(0, 1, 0, 16'h5A5A, 6'd0, 0);
    step(1, 0, 0, '0, '0, 1);
    step(1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 150; i++) rand_cycle(0, 1);

    // Illegal returns: unallocated slot 5, duplicate return to tag 1.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 0);
    step(0, 1, 0, 16'h0555, 6'd5, 0);
    step(0, 1, 0, 16'h1111, 6'd1, 0);
    step(0, 1, 0, 16'h2222, 6'd1, 0);
    step(0, 1, 0, 16'h0AAA, 6'd0, 0);
    step(0, 1, 0, 16'h0CCC, 6'd2, 0);
    idle(6, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 40; i++) rand_cycle(0, 1);

    // Random traffic, then drain.
    do_reset();
    for (int i = 0; i < 3000; i++) rand_cycle(1, 0);
    for (int i = 0; i < 200; i++) rand_cycle(0, 1);
    // Mid-operation reset followed by more traffic.
    for (int i = 0; i < 50; i++) rand_cycle(1, 0);
    do_reset();
    for (int i = 0; i < 500; i++) rand_cycle(1, 0);
    for (int i = 0; i < 200; i++) rand_cycle(0, 1);

    @(negedge clk); #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
